// File: rtl/pipe_if_param.sv
// Instruction-fetch stage: architectural PC, local instruction memory and IF/ID register.
// Define IF_IMEM_LOAD_EN to add a runtime write port to the memory; otherwise it is a ROM.
module pipe_if_param #(
   parameter int          ADDR_W   = 3,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
`ifdef IF_IMEM_LOAD_EN
   input  logic              ram_ena,
   input  logic              ram_wena,
   input  logic [ADDR_W-1:0] ram_waddr,
   input  logic [31:0]       ram_indata,
`endif
   output logic [31:0]       pc,
   output logic [31:0]       npc,
   output logic [31:0]       if_inst,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_npc,
   output logic              if_valid
);

   localparam int DEPTH = 1 << ADDR_W;

   // Contents are loaded at elaboration by the surrounding build.
   logic [31:0] mem [DEPTH];

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_npc_q, if_npc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] fetch_word;
   logic [31:0] npc_w;

   always_comb begin
      // Upper PC bits are dropped, so fetch addresses alias modulo the memory size.
      fetch_word = mem[pc_q[ADDR_W+1:2]];
      npc_w      = pc_q + 32'd4;
      pc_d       = pc_q;
      if_inst_d  = if_inst_q;
      if_pc_d    = if_pc_q;
      if_npc_d   = if_npc_q;
      if_valid_d = if_valid_q;
      if (redirect) begin
         // The fetch in flight is on the wrong path: squash it, even under stall.
         pc_d       = redirect_pc & 32'hFFFF_FFFC;
         if_inst_d  = 32'd0;
         if_valid_d = 1'b0;
      end else if (!stall) begin
         pc_d       = npc_w;
         if_inst_d  = fetch_word;
         if_pc_d    = pc_q;
         if_npc_d   = npc_w;
         if_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         if_inst_q  <= 32'd0;
         if_pc_q    <= 32'd0;
         if_npc_q   <= 32'd0;
         if_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if_inst_q  <= if_inst_d;
         if_pc_q    <= if_pc_d;
         if_npc_q   <= if_npc_d;
         if_valid_q <= if_valid_d;
      end
   end

`ifdef IF_IMEM_LOAD_EN
   // The read above is combinational from the pre-edge array, giving read-before-write.
   always_ff @(posedge clk) begin
      if (ram_ena && ram_wena) begin
         mem[ram_waddr] <= ram_indata;
      end
   end
`endif

   assign pc       = pc_q;
   assign npc      = npc_w;
   assign if_inst  = if_inst_q;
   assign if_pc    = if_pc_q;
   assign if_npc   = if_npc_q;
   assign if_valid = if_valid_q;

endmodule

// File: tb/tb_pipe_if_param.sv
// Bench for pipe_if_param: directed steps plus randomized traffic against a behavioural model.
// Works with and without IF_IMEM_LOAD_EN.
module tb_pipe_if_param;

   localparam int          ADDR_W   = 3;
   localparam int          DEPTH    = 1 << ADDR_W;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              stall = 1'b0;
   logic              redirect = 1'b0;
   logic [31:0]       redirect_pc = 32'd0;
`ifdef IF_IMEM_LOAD_EN
   logic              ram_ena = 1'b0;
   logic              ram_wena = 1'b0;
   logic [ADDR_W-1:0] ram_waddr = '0;
   logic [31:0]       ram_indata = 32'd0;
`endif
   logic [31:0]       pc, npc, if_inst, if_pc, if_npc;
   logic              if_valid;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the architectural state.
   logic [31:0] model_mem [DEPTH];
   logic [31:0] m_pc, m_inst, m_ipc, m_inpc;
   logic        m_valid;
   bit          ipc_known;

   pipe_if_param #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
`ifdef IF_IMEM_LOAD_EN
      .ram_ena(ram_ena),
      .ram_wena(ram_wena),
      .ram_waddr(ram_waddr),
      .ram_indata(ram_indata),
`endif
      .pc(pc),
      .npc(npc),
      .if_inst(if_inst),
      .if_pc(if_pc),
      .if_npc(if_npc),
      .if_valid(if_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("pc", pc, m_pc);
      chk("npc", npc, m_pc + 32'd4);
      chk("if_inst", if_inst, m_inst);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      if (ipc_known) begin
         chk("if_pc", if_pc, m_ipc);
         chk("if_npc", if_npc, m_inpc);
      end
   endtask

   // Apply one cycle of inputs, advance the model by the fetch-stage rules, compare.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      logic [31:0] fetched;
      int unsigned idx;
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
      @(posedge clk);
      #1;
      idx     = (m_pc / 4) % DEPTH;
      fetched = model_mem[idx];
      if (r) begin
         m_pc = RESET_PC; m_inst = 0; m_ipc = 0; m_inpc = 0; m_valid = 0; ipc_known = 1;
      end else if (rd) begin
         m_pc = rpc & 32'hFFFF_FFFC; m_inst = 0; m_valid = 0; ipc_known = 0;
      end else if (!s) begin
         m_inst = fetched; m_ipc = m_pc; m_inpc = m_pc + 32'd4; m_valid = 1; ipc_known = 1;
         m_pc = m_pc + 32'd4;
      end
`ifdef IF_IMEM_LOAD_EN
      if (ram_ena && ram_wena) model_mem[ram_waddr] = ram_indata;
`endif
      compare_all();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = $urandom;
      model_mem[0] = 32'h11; model_mem[1] = 32'h22;
      model_mem[2] = 32'h33; model_mem[3] = 32'h44;
      for (int i = 0; i < DEPTH; i++) dut.mem[i] = model_mem[i];
      m_pc = 0; m_inst = 0; m_ipc = 0; m_inpc = 0; m_valid = 0; ipc_known = 1;

      // Reset state, with redirect asserted to show reset wins.
      step(1, 0, 0, 32'd0);
      step(1, 1, 1, 32'h40);

      // First fetches after reset.
      step(0, 0, 0, 32'd0);
      chk("first_pc", pc, 32'h4);
      chk("first_if_inst", if_inst, 32'h11);
      step(0, 0, 0, 32'd0);
      chk("second_if_inst", if_inst, 32'h22);

      // Stall three cycles at pc=8, then resume with no loss or duplicate.
      chk("stall_start_pc", pc, 32'h8);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 32'd0);
      step(0, 0, 0, 32'd0);
      chk("resume_if_pc", if_pc, 32'h8);
      chk("resume_if_inst", if_inst, 32'h33);

      // Run past the end of the memory and check aliasing back to mem[0].
      while (pc != 32'h20 && checks < 5000) step(0, 0, 0, 32'd0);
      chk("wrap_pc", pc, 32'h20);
      step(0, 0, 0, 32'd0);
      chk("wrap_if_inst", if_inst, 32'h11);

      // Redirect with stall in the same cycle: unaligned target, one bubble.
      step(0, 1, 1, 32'h13);
      chk("redir_pc", pc, 32'h10);
      chk("redir_bubble", {31'd0, if_valid}, 32'd0);
      step(0, 0, 0, 32'd0);
      chk("redir_if_pc", if_pc, 32'h10);
      chk("redir_if_inst", if_inst, model_mem[4]);

      // Reset mid-run at pc=0x14; memory must survive.
      chk("pre_rst_pc", pc, 32'h14);
      step(1, 0, 0, 32'd0);
      for (int i = 0; i < DEPTH; i++) chk("mem_kept", dut.mem[i], model_mem[i]);
      step(0, 0, 0, 32'd0);

      // Randomized stall/redirect/reset traffic.
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), $urandom);
      end

`ifdef IF_IMEM_LOAD_EN
      // Write hitting the word being fetched: old data captured, new data next time.
      step(0, 0, 1, 32'h8);
      ram_ena = 1; ram_wena = 1; ram_waddr = 3'd2; ram_indata = 32'hDEAD_BEEF;
      step(0, 0, 0, 32'd0);
      chk("rbw_old_data", if_inst, 32'h33);
      ram_ena = 0; ram_wena = 0;
      step(0, 0, 1, 32'h8);
      step(0, 0, 0, 32'd0);
      chk("rbw_new_data", if_inst, 32'hDEAD_BEEF);
      // Enable without write enable must not write.
      ram_ena = 1; ram_wena = 0; ram_waddr = 3'd5; ram_indata = 32'h1234_5678;
      step(0, 0, 0, 32'd0);
      ram_ena = 0;
      chk("no_wena_write", dut.mem[5], model_mem[5]);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_if_param.md
Name: pipe_if_param

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline; successor to the fixed 8-word fetch block.
- Holds the architectural PC and a local instruction memory of 2^ADDR_W words.
- Feeds the IF/ID pipeline register with instruction, PC, PC+4 and a valid bit.
- Adds stall, branch/jump redirect with flush, and a configurable reset vector.

Parameters:
- ADDR_W, 3, instruction-memory index width; depth = 2^ADDR_W 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from ID; holds PC and the IF/ID register.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_pc  in  32  target PC for redirect.
- ram_ena  in  1  instruction-memory write port enable (IF_IMEM_LOAD_EN only).
- ram_wena  in  1  instruction-memory write enable (IF_IMEM_LOAD_EN only).
- ram_waddr  in  ADDR_W  word index for write (IF_IMEM_LOAD_EN only).
- ram_indata  in  32  write data (IF_IMEM_LOAD_EN only).
- pc  out  32  current fetch PC.
- npc  out  32  pc + 4, combinational.
- if_inst  out  32  IF/ID instruction.
- if_pc  out  32  IF/ID PC of if_inst.
- if_npc  out  32  IF/ID PC+4 of if_inst.
- if_valid  out  1  IF/ID contents are a real instruction (0 = bubble).

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Memory read:
  - Combinational: fetched word = mem[pc[ADDR_W+1:2]].
  - Upper PC bits are ignored, so addresses alias modulo 4*2^ADDR_W.
- Adder: npc = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000); carry is discarded.
- PC update, on each rising edge, in priority order:
  - rst: pc <= RESET_PC.
  - redirect: pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
  - stall: pc holds.
  - Otherwise: pc <= npc.
- IF/ID register update, same priority:
  - rst: if_inst <= 0 (NOP), if_pc <= 0, if_npc <= 0, if_valid <= 0.
  - redirect: if_valid <= 0 and if_inst <= 0 (flush). if_pc and if_npc take don't-care values; the bench must not check them.
  - stall: all IF/ID fields hold.
  - Otherwise: if_inst <= fetched word, if_pc <= pc, if_npc <= npc, if_valid <= 1.
- Redirect overrides stall in the same cycle. The fetch in flight is on the wrong path, so it is squashed.
- Latency:
  - First edge after rst deasserts: if_valid = 1 and if_pc = RESET_PC.
  - After redirect: exactly one bubble, then the target instruction appears in IF/ID.
- Reset mid-operation: rst takes precedence over every other input. Memory contents are not reset.
- Memory write (IF_IMEM_LOAD_EN):
  - Writes occur at the clock edge when ram_ena && ram_wena.
  - If a write hits the word being fetched in the same cycle, IF/ID captures the old data (read-before-write). The new data is visible from the next cycle.
- Memory initialisation: the $readmemh file name is set by the team's standard include; it is outside this block's interface.

Optional Feature:
- IF_IMEM_LOAD_EN defined:
  - The ram_ena, ram_wena, ram_waddr and ram_indata ports exist, and the memory is writable at runtime for program loading.
- IF_IMEM_LOAD_EN undefined:
  - Those four ports are absent.
  - The memory is a read-only ROM loaded only at elaboration.
  - All other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0 and mem[0..3]=0x11,0x22,0x33,0x44:
  - The cycle after reset: pc=4, if_pc=0, if_inst=0x11, if_valid=1.
  - The next cycle: if_pc=4, if_inst=0x22.
- Sequential run past the end of memory with ADDR_W=3:
  - After pc=0x1C, pc becomes 0x20 and the fetched word is mem[0] (aliasing).
  - if_npc tracks if_pc+4 throughout.
- stall held high for 3 cycles at pc=8:
  - pc stays 8, and if_inst/if_pc/if_valid are frozen for 3 cycles.
  - Fetch resumes at 8 with no instruction lost or duplicated.
- redirect=1, redirect_pc=0x13, stall=1 in the same cycle:
  - Next cycle: pc=0x10, if_valid=0, if_inst=0.
  - The following cycle: if_pc=0x10, if_inst=mem[4], if_valid=1.
- rst asserted mid-run at pc=0x14:
  - Next cycle: pc=RESET_PC, all IF/ID outputs are 0.
  - Memory contents are unchanged.
- IF_IMEM_LOAD_EN, write 0xDEAD_BEEF to index 2 while pc=8:
  - IF/ID captures the old mem[2].
  - After a redirect back to 8, the fetch returns 0xDEAD_BEEF.
